oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences the DMG OAM DMA. A CPU write to $FF46 copies 160 bytes from page XX00 to OAM at $FE00.
- Time-slices the source bus (cart / internal RAM) away from the CPU for the duration of the transfer.
- Flags CPU non-HRAM accesses as blocked while the transfer runs.
- Sits between the top-level bus decode, the cart/iram source mux and the video block's OAM write port.

Parameters:
- LEN, 160: bytes per transfer; index width is 8 bits.
- CPB, 4: clocks per byte slot; must be >= 2.
- START_DELAY, 4: idle clocks between the trigger and the first slot.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_sel  in  1  CPU address == $FF46.
- cpu_wr  in  1  CPU write strobe, active high; may stay high for several clocks.
- cpu_di  in  8  CPU write data (source page).
- cpu_do  out  8  readback of the last page written to $FF46.
- busy  out  1  transfer in progress (DELAY or XFER).
- cpu_block  out  1  top level must return block_do for CPU reads outside $FF80-$FFFE and drop those writes.
- block_do  out  8  data returned on blocked CPU reads.
- src_rd  out  1  source bus read request; owns cart/iram address mux when high.
- src_addr  out  16  source address.
- src_data  in  8  source read data, valid 1 clock after src_rd (synchronous RAM).
- oam_wr  out  1  OAM write pulse.
- oam_addr  out  8  OAM index 0..159.
- oam_data  out  8  OAM write data.

Behaviour:
- Reset (async) values:
  - state IDLE, page 8'h00, idx 0, slot counter 0.
  - busy, cpu_block, src_rd, oam_wr = 0.
  - src_addr 16'h0000, oam_addr 0, oam_data 8'h00, block_do 8'hFF, cpu_do 8'h00.
- Trigger = rising edge of (cpu_sel && cpu_wr), detected on an internal delayed copy of the strobe. A held strobe triggers exactly once.
- On trigger, page <= cpu_di and cpu_do <= cpu_di.
- Mirror rule: effective source high byte = page >= 8'hE0 ? page - 8'h20 : page (echo RAM maps to $C000-$DFFF).
- FSM states: IDLE, DELAY, XFER.
  - IDLE: trigger at clock T -> DELAY; busy = 1 from T+1.
  - DELAY: counts START_DELAY clocks (T+1..T+START_DELAY), then enters XFER with idx = 0, slot counter = 0. cpu_block = 0 in DELAY.
  - XFER: slot n occupies CPB clocks starting at T+START_DELAY+1+n*CPB.
    - Slot clock 0: src_rd = 1, src_addr = {eff_page, idx}.
    - Slot clock 1: oam_data <= src_data.
    - Slot clock CPB-1: oam_wr = 1, oam_addr = idx; idx increments after that clock.
    - cpu_block = 1 throughout XFER.
  - After the last clock of slot LEN-1 -> IDLE; busy and cpu_block drop on the next clock.
- Total busy time is START_DELAY + LEN*CPB clocks (644 with defaults).
- Restart: a trigger in DELAY or XFER latches the new page, aborts the current transfer immediately, and enters DELAY with idx = 0.
  - busy stays high continuously through the restart.
  - An oam_wr coinciding with the trigger clock still completes.
- Trigger on the same clock as the final oam_wr: that write completes, then DELAY is entered; no IDLE clock is inserted.
- src_rd and oam_wr are single-clock pulses, never high in DELAY or IDLE.
- $FF46 reads: cpu_do is always valid and is not blocked.
- Reset mid-transfer: returns to IDLE at once; OAM keeps any bytes already written.

Optional Feature:
- Macro: OAM_DMA_CONFLICT_EN.
- Defined:
  - block_do <= src_data at slot clock 1 of each slot, so blocked CPU reads return the byte currently being DMA'd (hardware bus-conflict behaviour).
  - block_do resets to 8'hFF and holds its last value after the transfer ends.
- Undefined: block_do is constant 8'hFF.

Test Plan:
- Basic copy:
  - Stimulus: preload $C000-$C09F with i^8'h5A; write $C0 to $FF46 (strobe held 3 clocks).
  - Required: exactly one trigger; busy high for 644 clocks; 160 oam_wr pulses; OAM[i] == i^8'h5A; cpu_do == 8'hC0.
- Slot timing:
  - Stimulus: trigger at clock T.
  - Required: first src_rd at T+5 with src_addr $C000; first oam_wr at T+8 with oam_addr 0; second src_rd at T+9 with src_addr $C001.
- Echo mirror:
  - Stimulus: write $E1.
  - Required: src_addr runs $C100..$C19F; cpu_do reads $E1.
- Restart:
  - Stimulus: write $C0, then write $80 during slot 50.
  - Required: busy never drops; DELAY again for 4 clocks; next src_addr is $8000; OAM[0..159] ends holding the $8000 data.
- Blocking and async reset:
  - cpu_block is 0 during DELAY and 1 during XFER.
  - Assert reset at slot 10: all outputs take reset values within the same clock; OAM[0..9] are written, OAM[10..] are untouched.
- Conflict (macro defined vs undefined):
  - Stimulus: read block_do during slot 3 of a $C0 copy.
  - Required: macro defined -> 3^8'h5A; macro undefined -> 8'hFF.

Source files
------------

// File: rtl/oam_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl_if
// Bundles the OAM DMA controller's CPU, source-bus and OAM write signals.
//   CPU side    : cpu_sel, cpu_wr, cpu_di (to DMA); cpu_do, busy, cpu_block,
//                 block_do (from DMA)
//   Source bus  : src_rd, src_addr (from DMA); src_data (to DMA)
//   OAM port    : oam_wr, oam_addr, oam_data (from DMA)
// Modports: master = bus/system side, slave = the DMA controller.
// ---------------------------------------------------------------------------
interface oam_dma_ctrl_if;
  logic        cpu_sel;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        busy;
  logic        cpu_block;
  logic [7:0]  block_do;
  logic        src_rd;
  logic [15:0] src_addr;
  logic [7:0]  src_data;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;

  modport master (
    output cpu_sel, cpu_wr, cpu_di, src_data,
    input  cpu_do, busy, cpu_block, block_do, src_rd, src_addr,
           oam_wr, oam_addr, oam_data
  );

  modport slave (
    input  cpu_sel, cpu_wr, cpu_di, src_data,
    output cpu_do, busy, cpu_block, block_do, src_rd, src_addr,
           oam_wr, oam_addr, oam_data
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// DMG OAM DMA sequencer. A write to $FF46 copies LEN bytes from page XX00
// into OAM, one byte every CPB clocks, after START_DELAY idle clocks.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : oam_dma_ctrl_if.slave (CPU strobe/data, source bus, OAM port)
// Optional build macro:
//   OAM_DMA_CONFLICT_EN - block_do tracks the byte being DMA'd (bus conflict);
//                         otherwise block_do is constant 8'hFF.
//
// state | meaning
// IDLE  | no transfer, CPU owns the bus
// DELAY | START_DELAY clocks after a trigger, CPU not yet blocked
// XFER  | LEN slots of CPB clocks: read source, then write OAM
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter int LEN         = 160,
  parameter int CPB         = 4,
  parameter int START_DELAY = 4
) (
  input  logic            clk,
  input  logic            reset,
  oam_dma_ctrl_if.slave   bus
);

  localparam int SW = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      page_q;
  logic [7:0]      oam_data_q;
  logic            strobe_q;

  logic            trig;
  logic            in_xfer;
  logic            slot_first;
  logic            slot_data;
  logic            slot_last;
  logic            idx_last;
  logic [7:0]      eff_page;

  // Edge detect so a strobe held over several clocks starts only one copy.
  assign trig       = bus.cpu_sel && bus.cpu_wr && !strobe_q;
  assign in_xfer    = (state_q == S_XFER);
  assign slot_first = (slot_q == '0);
  assign slot_data  = (slot_q == SW'(1));
  assign slot_last  = (slot_q == SW'(CPB - 1));
  assign idx_last   = (idx_q == 8'(LEN - 1));

  // Echo RAM pages $E0-$FF fold down onto $C0-$DF.
  assign eff_page = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: ;
      S_DELAY: begin
        if (dly_q == '0) begin
          state_d = S_XFER;
          slot_d  = '0;
          idx_d   = 8'h00;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      S_XFER: begin
        if (slot_last) begin
          slot_d = '0;
          if (idx_last) begin
            state_d = S_IDLE;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'h01;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new trigger always wins: restart from DELAY with the new page.
    if (trig) begin
      state_d = S_DELAY;
      dly_d   = DW'(START_DELAY - 1);
      slot_d  = '0;
      idx_d   = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      slot_q     <= '0;
      idx_q      <= 8'h00;
      page_q     <= 8'h00;
      oam_data_q <= 8'h00;
      strobe_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      strobe_q <= bus.cpu_sel && bus.cpu_wr;
      if (trig)
        page_q <= bus.cpu_di;
      if (in_xfer && slot_data)
        oam_data_q <= bus.src_data;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cpu_block = in_xfer;
  assign bus.cpu_do    = page_q;
  assign bus.src_rd    = in_xfer && slot_first;
  assign bus.src_addr  = bus.src_rd ? {eff_page, idx_q} : 16'h0000;
  assign bus.oam_wr    = in_xfer && slot_last;
  assign bus.oam_addr  = idx_q;
  // Bypass the capture register on slot clock 1 so CPB == 2 still writes
  // the freshly read byte.
  assign bus.oam_data  = (in_xfer && slot_data) ? bus.src_data : oam_data_q;

`ifdef OAM_DMA_CONFLICT_EN
  logic [7:0] block_do_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      block_do_q <= 8'hFF;
    else if (in_xfer && slot_data)
      block_do_q <= bus.src_data;
  end

  assign bus.block_do = block_do_q;
`else
  assign bus.block_do = 8'hFF;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [7:0] mem [65536];
  logic [7:0] oam [160];

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(.LEN(160), .CPB(4), .START_DELAY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous source RAM and OAM models.
  always @(posedge clk) begin
    if (bus.src_rd)
      bus.src_data <= mem[bus.src_addr];
    if (bus.oam_wr && !reset)
      oam[bus.oam_addr] <= bus.oam_data;
  end

  task automatic drive_ff46(input logic [7:0] v);
    bus.cpu_sel = 1'b1;
    bus.cpu_wr  = 1'b1;
    bus.cpu_di  = v;
  endtask

  task automatic release_ff46;
    bus.cpu_sel = 1'b0;
    bus.cpu_wr  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cpu_block !== 1'b0 || bus.src_rd !== 1'b0 ||
        bus.oam_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b blk=%b rd=%b wr=%b expected all 0",
               bus.busy, bus.cpu_block, bus.src_rd, bus.oam_wr);
    end
    checks++;
    if (bus.src_addr !== 16'h0000 || bus.oam_addr !== 8'h00 ||
        bus.oam_data !== 8'h00 || bus.block_do !== 8'hFF || bus.cpu_do !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: src_addr=%h oam_addr=%h oam_data=%h block_do=%h cpu_do=%h expected 0000 00 00 ff 00",
               bus.src_addr, bus.oam_addr, bus.oam_data, bus.block_do, bus.cpu_do);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Basic copy with a 3-clock strobe, plus first-slot timing.
  task automatic test_basic;
    int busy_n, last_busy, wr_n, rd_n, blk_n, bad_pulse, dly_blk, bad;
    busy_n = 0; last_busy = 0; wr_n = 0; rd_n = 0; blk_n = 0;
    bad_pulse = 0; dly_blk = 0; bad = 0;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
      oam[i] = 8'h00;
    end
    drive_ff46(8'hC0);
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (k == 3) release_ff46();
      if (bus.busy) begin busy_n++; last_busy = k; end
      if (bus.cpu_block) blk_n++;
      if (k <= 4 && bus.cpu_block) dly_blk++;
      if ((bus.src_rd || bus.oam_wr) && !bus.cpu_block) bad_pulse++;
      if (bus.src_rd) begin
        if (rd_n == 0) begin
          checks++;
          if (k != 5 || bus.src_addr !== 16'hC000) begin
            errors++;
            $display("FAIL first_src_rd: cycle=%0d addr=%h expected cycle 5 addr c000", k, bus.src_addr);
          end
        end
        if (rd_n == 1) begin
          checks++;
          if (k != 9 || bus.src_addr !== 16'hC001) begin
            errors++;
            $display("FAIL second_src_rd: cycle=%0d addr=%h expected cycle 9 addr c001", k, bus.src_addr);
          end
        end
        rd_n++;
      end
      if (bus.oam_wr) begin
        if (wr_n == 0) begin
          checks++;
          if (k != 8 || bus.oam_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_oam_wr: cycle=%0d oam_addr=%h expected cycle 8 addr 00", k, bus.oam_addr);
          end
        end
        wr_n++;
      end
    end
    checks++;
    if (busy_n != 644 || last_busy != 644) begin
      errors++;
      $display("FAIL basic_busy: busy_cycles=%0d last=%0d expected 644 644", busy_n, last_busy);
    end
    checks++;
    if (wr_n != 160 || rd_n != 160) begin
      errors++;
      $display("FAIL basic_pulses: oam_wr=%0d src_rd=%0d expected 160 160", wr_n, rd_n);
    end
    checks++;
    if (blk_n != 640 || dly_blk != 0 || bad_pulse != 0) begin
      errors++;
      $display("FAIL basic_block: blk_cycles=%0d blk_in_delay=%0d stray_pulses=%0d expected 640 0 0",
               blk_n, dly_blk, bad_pulse);
    end
    for (int i = 0; i < 160; i++)
      if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_oam: %0d bytes wrong expected 0", bad);
    end
    checks++;
    if (bus.cpu_do !== 8'hC0) begin
      errors++;
      $display("FAIL basic_cpu_do: got %h expected c0", bus.cpu_do);
    end
  endtask

  task automatic test_echo;
    int n, bad, bad_oam;
    n = 0; bad = 0; bad_oam = 0;
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h33;
    drive_ff46(8'hE1);
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (k == 1) release_ff46();
      if (k == 100) begin
        checks++;
        if (bus.cpu_do !== 8'hE1) begin
          errors++;
          $display("FAIL echo_cpu_do: got %h expected e1", bus.cpu_do);
        end
      end
      if (bus.src_rd) begin
        if (bus.src_addr !== (16'hC100 + 16'(n))) bad++;
        n++;
      end
    end
    checks++;
    if (n != 160 || bad != 0) begin
      errors++;
      $display("FAIL echo_addr: reads=%0d wrong_addr=%0d expected 160 0", n, bad);
    end
    for (int i = 0; i < 160; i++)
      if (oam[i] !== (8'(i) ^ 8'h33)) bad_oam++;
    checks++;
    if (bad_oam != 0) begin
      errors++;
      $display("FAIL echo_oam: %0d bytes wrong expected 0", bad_oam);
    end
  endtask

  // Restart at slot 50 clock 3, coinciding with that slot's oam_wr.
  task automatic test_restart;
    int drop, busy_n, last_busy, dly_blk, first_rd, bad;
    logic [15:0] first_addr;
    drop = 0; busy_n = 0; last_busy = 0; dly_blk = 0; first_rd = 0; bad = 0;
    first_addr = 16'h0000;
    for (int i = 0; i < 160; i++) begin
      mem[16'h8000 + i] = 8'(i) ^ 8'hA5;
      oam[i] = 8'h00;
    end
    drive_ff46(8'hC0);
    for (int k = 1; k <= 208; k++) begin
      @(negedge clk);
      if (k == 1) release_ff46();
      if (!bus.busy) drop++;
    end
    checks++;
    if (bus.oam_wr !== 1'b1 || bus.oam_addr !== 8'd50) begin
      errors++;
      $display("FAIL restart_setup: oam_wr=%b oam_addr=%0d expected 1 50", bus.oam_wr, bus.oam_addr);
    end
    drive_ff46(8'h80);
    for (int j = 1; j <= 700; j++) begin
      @(negedge clk);
      if (j == 1) begin
        release_ff46();
        checks++;
        if (oam[50] !== (8'd50 ^ 8'h5A)) begin
          errors++;
          $display("FAIL restart_last_wr: oam[50]=%h expected %h", oam[50], 8'd50 ^ 8'h5A);
        end
      end
      if (bus.busy) begin busy_n++; last_busy = j; end
      if (j <= 4 && (bus.cpu_block || bus.src_rd)) dly_blk++;
      if (bus.src_rd && first_rd == 0) begin
        first_rd = j;
        first_addr = bus.src_addr;
      end
    end
    checks++;
    if (drop != 0 || busy_n != 644 || last_busy != 644) begin
      errors++;
      $display("FAIL restart_busy: drops=%0d busy_cycles=%0d last=%0d expected 0 644 644",
               drop, busy_n, last_busy);
    end
    checks++;
    if (dly_blk != 0 || first_rd != 5 || first_addr !== 16'h8000) begin
      errors++;
      $display("FAIL restart_delay: delay_activity=%0d first_rd_cycle=%0d addr=%h expected 0 5 8000",
               dly_blk, first_rd, first_addr);
    end
    for (int i = 0; i < 160; i++)
      if (oam[i] !== (8'(i) ^ 8'hA5)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL restart_oam: %0d bytes wrong expected 0", bad);
    end
  endtask

  // Trigger on the same clock as the final oam_wr of a transfer.
  task automatic test_back_to_back;
    int drop, first_rd, dly_blk;
    logic [15:0] first_addr;
    drop = 0; first_rd = 0; dly_blk = 0; first_addr = 16'h0000;
    oam[159] = 8'h00;
    drive_ff46(8'hC0);
    for (int k = 1; k <= 644; k++) begin
      @(negedge clk);
      if (k == 1) release_ff46();
    end
    checks++;
    if (bus.oam_wr !== 1'b1 || bus.oam_addr !== 8'd159) begin
      errors++;
      $display("FAIL b2b_final_wr: oam_wr=%b oam_addr=%0d expected 1 159", bus.oam_wr, bus.oam_addr);
    end
    drive_ff46(8'hC0);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) release_ff46();
      if (!bus.busy) drop++;
      if (j <= 4 && bus.cpu_block) dly_blk++;
      if (bus.src_rd && first_rd == 0) begin
        first_rd = j;
        first_addr = bus.src_addr;
      end
    end
    checks++;
    if (drop != 0 || dly_blk != 0 || first_rd != 5 || first_addr !== 16'hC000) begin
      errors++;
      $display("FAIL b2b_restart: drops=%0d blk_in_delay=%0d first_rd_cycle=%0d addr=%h expected 0 0 5 c000",
               drop, dly_blk, first_rd, first_addr);
    end
    checks++;
    if (oam[159] !== (8'd159 ^ 8'h5A)) begin
      errors++;
      $display("FAIL b2b_oam159: got %h expected %h", oam[159], 8'd159 ^ 8'h5A);
    end
    for (int j = 9; j <= 660; j++) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_conflict;
    logic [7:0] exp_bd;
`ifdef OAM_DMA_CONFLICT_EN
    exp_bd = 8'h03 ^ 8'h5A;
`else
    exp_bd = 8'hFF;
`endif
    drive_ff46(8'hC0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) release_ff46();
    end
    checks++;
    if (bus.block_do !== exp_bd || bus.cpu_block !== 1'b1) begin
      errors++;
      $display("FAIL conflict_block_do: block_do=%h cpu_block=%b expected %h 1",
               bus.block_do, bus.cpu_block, exp_bd);
    end
    for (int k = 21; k <= 660; k++) @(negedge clk);
  endtask

  // Async reset in the middle of slot 10.
  task automatic test_reset_mid;
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++) oam[i] = 8'hEE;
    drive_ff46(8'hC0);
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      if (k == 1) release_ff46();
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cpu_block !== 1'b0 || bus.src_rd !== 1'b0 ||
        bus.oam_wr !== 1'b0 || bus.src_addr !== 16'h0000 || bus.oam_addr !== 8'h00 ||
        bus.oam_data !== 8'h00 || bus.block_do !== 8'hFF || bus.cpu_do !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy=%b blk=%b rd=%b wr=%b sa=%h oa=%h od=%h bd=%h cd=%h expected 0 0 0 0 0000 00 00 ff 00",
               bus.busy, bus.cpu_block, bus.src_rd, bus.oam_wr, bus.src_addr,
               bus.oam_addr, bus.oam_data, bus.block_do, bus.cpu_do);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 160; i++) begin
      if (i < 10 && oam[i] !== (8'(i) ^ 8'h5A)) bad++;
      if (i >= 10 && oam[i] !== 8'hEE) bad++;
    end
    checks++;
    if (bad != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_oam: wrong_bytes=%0d busy=%b expected 0 0", bad, bus.busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.cpu_sel  = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_di   = 8'h00;
    bus.src_data = 8'h00;
    for (int i = 0; i < 160; i++) oam[i] = 8'h00;
    test_reset();
    test_basic();
    test_echo();
    test_restart();
    test_back_to_back();
    test_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
